// File: rtl/tcp_tx_sequencer.sv
// TCP transmit sequencer: issues one tx request to the stack, retries failed
// requests after a back-off, then forwards (or drains) the payload and reports
// a single final status upstream per accepted request.
module tcp_tx_sequencer #(
  parameter int unsigned DATA_BITS   = 512,
  parameter int unsigned RETRY_DELAY = 64,
  parameter int unsigned MAX_RETRY   = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  // upstream tx request
  input  logic                   s_meta_valid,
  output logic                   s_meta_ready,
  input  logic [31:0]            s_meta_data,
  // tx request to the stack
  output logic                   m_meta_valid,
  input  logic                   m_meta_ready,
  output logic [31:0]            m_meta_data,
  // stack tx status
  input  logic                   s_stat_valid,
  output logic                   s_stat_ready,
  input  logic [63:0]            s_stat_data,
  // final status upstream
  output logic                   m_stat_valid,
  input  logic                   m_stat_ready,
  output logic [63:0]            m_stat_data,
  // upstream payload
  input  logic [DATA_BITS-1:0]   s_data_tdata,
  input  logic [DATA_BITS/8-1:0] s_data_tkeep,
  input  logic                   s_data_tlast,
  input  logic                   s_data_tvalid,
  output logic                   s_data_tready,
  // payload to the stack
  output logic [DATA_BITS-1:0]   m_data_tdata,
  output logic [DATA_BITS/8-1:0] m_data_tkeep,
  output logic                   m_data_tlast,
  output logic                   m_data_tvalid,
  input  logic                   m_data_tready,
  output logic [5:0]             m_data_tid
);

  typedef enum logic [2:0] {
    StIdle, StMeta, StWaitStat, StBackoff, StData, StDrain, StReport
  } state_e;

  state_e       state_q;
  logic         armed_q;   // holds s_meta_ready low for the first cycle after reset
  logic [15:0]  sid_q;
  logic [15:0]  len_q;
  logic [31:0]  stat_hi_q; // error/space of the latched status
  logic [31:0]  retry_q;
  logic [31:0]  delay_q;
  logic [19:0]  beats_q;

  // Upstream tlast is untrusted; tlast is regenerated from the beat counter.
  logic unused_tlast;
  assign unused_tlast = s_data_tlast;

  // Number of DATA_BITS-wide beats needed to carry len bytes.
  function automatic logic [19:0] calc_beats(input logic [15:0] len);
    logic [31:0] bits;
    bits = {13'd0, len, 3'd0};
    return 20'((bits + DATA_BITS - 32'd1) / DATA_BITS);
  endfunction

  // Request sequencing FSM with its counters and latched request/status.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      sid_q     <= '0;
      len_q     <= '0;
      stat_hi_q <= '0;
      retry_q   <= '0;
      delay_q   <= '0;
      beats_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (s_meta_valid && s_meta_ready) begin
            sid_q   <= s_meta_data[15:0];
            len_q   <= s_meta_data[31:16];
            retry_q <= '0;
            if (s_meta_data[31:16] == 16'd0) begin
              stat_hi_q <= '0;
              state_q   <= StReport;
            end else begin
              state_q <= StMeta;
            end
          end
        end
        StMeta: begin
          if (m_meta_ready) state_q <= StWaitStat;
        end
        StWaitStat: begin
          if (s_stat_valid) begin
            stat_hi_q <= s_stat_data[63:32];
            if (s_stat_data[63:62] == 2'b00) begin
              beats_q <= calc_beats(len_q);
              state_q <= StData;
            end else if (retry_q < MAX_RETRY) begin
              retry_q <= retry_q + 32'd1;
              delay_q <= '0;
              state_q <= StBackoff;
            end else begin
              // Out of retries: swallow the payload so upstream is not stuck.
              beats_q <= calc_beats(len_q);
              state_q <= StDrain;
            end
          end
        end
        StBackoff: begin
          if (delay_q + 32'd1 >= RETRY_DELAY) state_q <= StMeta;
          else delay_q <= delay_q + 32'd1;
        end
        StData: begin
          if (s_data_tvalid && m_data_tready) begin
            beats_q <= beats_q - 20'd1;
            if (beats_q == 20'd1) state_q <= StReport;
          end
        end
        StDrain: begin
          if (s_data_tvalid) begin
            beats_q <= beats_q - 20'd1;
            if (beats_q == 20'd1) state_q <= StReport;
          end
        end
        StReport: begin
          if (m_stat_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake signals decoded from the registered state; payload passes straight through.
  always_comb begin
    s_meta_ready  = (state_q == StIdle) && armed_q;
    m_meta_valid  = (state_q == StMeta);
    s_stat_ready  = (state_q == StWaitStat);
    m_stat_valid  = (state_q == StReport);
    s_data_tready = ((state_q == StData) && m_data_tready) || (state_q == StDrain);
    m_data_tvalid = (state_q == StData) && s_data_tvalid;
    m_data_tlast  = (state_q == StData) && (beats_q == 20'd1);
  end

  assign m_meta_data  = {len_q, sid_q};
  assign m_stat_data  = {stat_hi_q, len_q, sid_q};
  assign m_data_tdata = s_data_tdata;
  assign m_data_tkeep = s_data_tkeep;
  assign m_data_tid   = '0;

endmodule

// File: tb/tb_tcp_tx_sequencer.sv
// Self-checking bench for tcp_tx_sequencer: table of requests driven through
// upstream/stack models, scoreboard queues for data beats and final status,
// plus a reset-in-DATA sequence.
module tb_tcp_tx_sequencer;

  localparam int unsigned DB     = 512;
  localparam int unsigned RD     = 8;
  localparam int unsigned MR     = 2;
  localparam int          BUDGET = 2000;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            s_meta_valid = 1'b0;
  logic            s_meta_ready;
  logic [31:0]     s_meta_data = '0;
  logic            m_meta_valid;
  logic            m_meta_ready = 1'b0;
  logic [31:0]     m_meta_data;
  logic            s_stat_valid = 1'b0;
  logic            s_stat_ready;
  logic [63:0]     s_stat_data = '0;
  logic            m_stat_valid;
  logic            m_stat_ready = 1'b0;
  logic [63:0]     m_stat_data;
  logic [DB-1:0]   s_data_tdata = '0;
  logic [DB/8-1:0] s_data_tkeep = '0;
  logic            s_data_tlast = 1'b0;
  logic            s_data_tvalid = 1'b0;
  logic            s_data_tready;
  logic [DB-1:0]   m_data_tdata;
  logic [DB/8-1:0] m_data_tkeep;
  logic            m_data_tlast;
  logic            m_data_tvalid;
  logic            m_data_tready = 1'b0;
  logic [5:0]      m_data_tid;

  tcp_tx_sequencer #(.DATA_BITS(DB), .RETRY_DELAY(RD), .MAX_RETRY(MR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_data(s_meta_data),
    .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_data(m_meta_data),
    .s_stat_valid(s_stat_valid), .s_stat_ready(s_stat_ready), .s_stat_data(s_stat_data),
    .m_stat_valid(m_stat_valid), .m_stat_ready(m_stat_ready), .m_stat_data(m_stat_data),
    .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep), .s_data_tlast(s_data_tlast),
    .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
    .m_data_tdata(m_data_tdata), .m_data_tkeep(m_data_tkeep), .m_data_tlast(m_data_tlast),
    .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready), .m_data_tid(m_data_tid)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0]      sid;
    logic [15:0]      len;
    logic [2:0][1:0]  errs;       // errs[i] = stack error returned for issue i
    bit               bad_tlast;  // upstream raises tlast on beat 0
    bit               stall;
    int               exp_issues;
    int               exp_beats;  // beats expected on m_data
    logic [1:0]       exp_err;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          meta_cnt, data_cnt, last_meta_cyc, meta_hs_cyc, stat_cyc;
  bit          stat_ok;
  bit          stall_en = 1'b0;
  logic [31:0] exp_meta;
  logic [63:0] exp_data[$];
  logic [63:0] exp_stat[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] kp(input int b);
    return 16'(b) ^ 16'hA5A5;
  endfunction

  function automatic vec_t mk(input logic [15:0] sid, input logic [15:0] len,
                              input logic [5:0] errs, input bit bad, input bit stall,
                              input int iss, input int beats, input logic [1:0] err);
    vec_t v;
    v.sid = sid; v.len = len; v.errs = errs; v.bad_tlast = bad; v.stall = stall;
    v.exp_issues = iss; v.exp_beats = beats; v.exp_err = err;
    return v;
  endfunction

  always @(posedge aclk) cyc++;

  // Downstream ready generator: random stalls when enabled.
  always @(posedge aclk) begin
    #1;
    if (stall_en) begin
      m_data_tready = ($urandom_range(0, 3) != 0);
      m_meta_ready  = ($urandom_range(0, 2) != 0);
      m_stat_ready  = ($urandom_range(0, 2) != 0);
    end else begin
      m_data_tready = 1'b1;
      m_meta_ready  = 1'b1;
      m_stat_ready  = 1'b1;
    end
  end

  // Monitors: sampled on the falling edge, a valid&ready seen here completes next rise.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_meta_valid && m_meta_ready) begin
        meta_cnt++;
        check("m_meta_data", 64'(m_meta_data), 64'(exp_meta));
        if (meta_cnt > 1) check("backoff_gap", 64'((cyc - last_meta_cyc) > RD), 64'd1);
        last_meta_cyc = cyc;
      end
      if (m_data_tvalid && m_data_tready) begin
        data_cnt++;
        check("data_after_ok_stat", 64'(stat_ok), 64'd1);
        check("m_data_tid", 64'(m_data_tid), 64'd0);
        if (exp_data.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
        else check("m_data_beat", {15'd0, m_data_tlast, m_data_tkeep[15:0], m_data_tdata[31:0]},
                   exp_data.pop_front());
      end
      if (m_stat_valid && m_stat_ready) begin
        stat_cyc = cyc;
        if (exp_stat.size() == 0) check("unexpected_stat", 64'd1, 64'd0);
        else check("m_stat_data", m_stat_data, exp_stat.pop_front());
      end
    end
  end

  task automatic check_idle(input string name);
    check(name, {56'd0, s_meta_ready, m_meta_valid, s_stat_ready, m_stat_valid,
                 s_data_tready, m_data_tvalid, m_data_tlast, |m_data_tid}, 64'd0);
  endtask

  task automatic run_req(input vec_t v);
    int          nb;
    int          n;
    logic [29:0] sp;
    nb = (int'(v.len) + 63) / 64;
    sp = (v.exp_issues == 0) ? 30'd0 : 30'(int'(v.sid) * 4 + v.exp_issues - 1);
    stall_en = v.stall;
    meta_cnt = 0; data_cnt = 0; stat_ok = 1'b0;
    exp_meta = {v.len, v.sid};
    for (int b = 0; b < v.exp_beats; b++)
      exp_data.push_back({15'd0, b == v.exp_beats - 1, kp(b), v.sid, 16'(b)});
    exp_stat.push_back({v.exp_err, sp, v.len, v.sid});
    fork
      begin : meta_drv
        @(posedge aclk); #1;
        s_meta_valid = 1'b1; s_meta_data = {v.len, v.sid};
        n = 0;
        do begin @(negedge aclk); n++; end while (!s_meta_ready && n < BUDGET);
        if (!s_meta_ready) check("s_meta_timeout", 64'd0, 64'd1);
        meta_hs_cyc = cyc;
        @(posedge aclk); #1; s_meta_valid = 1'b0;
      end
      begin : stat_drv
        int m;
        for (int i = 0; i < v.exp_issues; i++) begin
          @(posedge aclk); #1;
          s_stat_valid = 1'b1;
          // sid/len deliberately differ from the request: m_stat must carry the request's
          s_stat_data = {v.errs[i], 30'(int'(v.sid) * 4 + i), ~v.len, ~v.sid};
          m = 0;
          do begin @(negedge aclk); m++; end while (!s_stat_ready && m < BUDGET);
          if (!s_stat_ready) begin
            check("s_stat_timeout", 64'd0, 64'd1);
            break;
          end
          check("stat_after_meta", 64'(meta_cnt), 64'(i + 1));
          if (v.errs[i] == 2'd0) stat_ok = 1'b1;
          @(posedge aclk); #1; s_stat_valid = 1'b0;
        end
        @(posedge aclk); #1; s_stat_valid = 1'b0;
      end
      begin : data_drv
        int k;
        for (int b = 0; b < nb; b++) begin
          @(posedge aclk); #1;
          if (v.stall && $urandom_range(0, 2) == 0) begin
            s_data_tvalid = 1'b0;
            @(posedge aclk); #1;
          end
          s_data_tvalid = 1'b1;
          s_data_tdata  = {16{v.sid, 16'(b)}};
          s_data_tkeep  = {4{kp(b)}};
          s_data_tlast  = v.bad_tlast ? (b == 0) : (b == nb - 1);
          k = 0;
          do begin @(negedge aclk); k++; end while (!s_data_tready && k < BUDGET);
          if (!s_data_tready) begin
            check("s_data_timeout", 64'd0, 64'd1);
            break;
          end
        end
        @(posedge aclk); #1; s_data_tvalid = 1'b0;
      end
    join
    n = 0;
    while (exp_stat.size() != 0 && n < BUDGET) begin @(negedge aclk); n++; end
    check("m_stat_produced", 64'(exp_stat.size()), 64'd0);
    check("m_meta_issues", 64'(meta_cnt), 64'(v.exp_issues));
    check("m_data_beats", 64'(data_cnt), 64'(v.exp_beats));
    if (v.len == 16'd0) check("len0_latency", 64'((stat_cyc - meta_hs_cyc) <= 3), 64'd1);
    exp_data.delete();
  endtask

  initial begin
    int n;
    //            sid    len      errs{e2,e1,e0}       bad stl iss bts err
    vecs[0] = mk(16'd5,  16'd128, {2'd0, 2'd0, 2'd0}, 0,  0,  1,  2,  2'd0);
    vecs[1] = mk(16'd7,  16'd100, {2'd0, 2'd0, 2'd0}, 1,  0,  1,  2,  2'd0);
    vecs[2] = mk(16'd9,  16'd64,  {2'd0, 2'd0, 2'd1}, 0,  0,  2,  1,  2'd0);
    vecs[3] = mk(16'd11, 16'd200, {2'd2, 2'd2, 2'd2}, 0,  0,  3,  0,  2'd2);
    vecs[4] = mk(16'd12, 16'd0,   {2'd0, 2'd0, 2'd0}, 0,  0,  0,  0,  2'd0);
    vecs[5] = mk(16'd13, 16'd1,   {2'd0, 2'd0, 2'd3}, 0,  1,  2,  1,  2'd0);
    vecs[6] = mk(16'd14, 16'd513, {2'd0, 2'd0, 2'd0}, 0,  1,  1,  9,  2'd0);
    vecs[7] = mk(16'd15, 16'd192, {2'd0, 2'd3, 2'd1}, 0,  1,  3,  3,  2'd0);

    repeat (3) @(negedge aclk);
    check_idle("outputs_in_reset");
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("s_meta_ready_after_reset", 64'(s_meta_ready), 64'd1);

    for (int i = 0; i < 8; i++) run_req(vecs[i]);

    // Reset pulse while forwarding payload.
    stall_en = 1'b1; meta_cnt = 0; data_cnt = 0; stat_ok = 1'b0;
    exp_meta = {16'd640, 16'd20};
    for (int b = 0; b < 10; b++)
      exp_data.push_back({15'd0, b == 9, kp(b), 16'd20, 16'(b)});
    exp_stat.push_back({2'd0, 30'd1, 16'd640, 16'd20});
    @(posedge aclk); #1; s_meta_valid = 1'b1; s_meta_data = {16'd640, 16'd20};
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_meta_ready && n < BUDGET);
    @(posedge aclk); #1; s_meta_valid = 1'b0;
    s_stat_valid = 1'b1; s_stat_data = {2'd0, 30'd1, 16'd640, 16'd20};
    n = 0;
    do begin @(negedge aclk); n++; end while (!s_stat_ready && n < BUDGET);
    if (!s_stat_ready) check("rst_seq_stat_timeout", 64'd0, 64'd1);
    stat_ok = 1'b1;
    @(posedge aclk); #1; s_stat_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (b != 0) begin @(posedge aclk); #1; end
      s_data_tvalid = 1'b1; s_data_tdata = {16{16'd20, 16'(b)}}; s_data_tkeep = {4{kp(b)}};
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_data_tready && n < BUDGET);
      if (!s_data_tready) check("rst_seq_data_timeout", 64'd0, 64'd1);
    end
    @(posedge aclk); #1;
    s_data_tdata = {16{16'd20, 16'd3}}; s_data_tkeep = {4{kp(3)}};
    #2 aresetn = 1'b0;
    check("beats_before_reset", 64'(data_cnt), 64'd3);
    exp_data.delete();
    exp_stat.delete();
    #1 check_idle("outputs_during_mid_reset");
    @(negedge aclk); @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    check("s_meta_ready_after_mid_reset", 64'(s_meta_ready), 64'd1);
    s_stat_valid = 1'b1;
    repeat (20) @(negedge aclk);
    check("no_beats_after_reset", 64'(data_cnt), 64'd3);
    check("idle_after_reset", {61'd0, m_meta_valid, m_stat_valid, m_data_tvalid}, 64'd0);
    check("stat_backpressured_idle", 64'(s_stat_ready), 64'd0);
    @(posedge aclk); #1; s_data_tvalid = 1'b0; s_stat_valid = 1'b0;

    run_req(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tcp_tx_sequencer.md
TCP_TX_SEQUENCER -- requirements
Module: tcp_tx_sequencer

Interface
REQ-001 SHALL have parameter DATA_BITS, default 512, width of the TCP tx data stream.
REQ-002 SHALL have parameter RETRY_DELAY, default 64, idle cycles between a failed request and its reissue.
REQ-003 SHALL have parameter MAX_RETRY, default 8, number of reissues allowed after the first failure.
REQ-004 aclk  in  1  sole clock; all logic is rising-edge.
REQ-005 aresetn  in  1  reset, asynchronous and active-low.
REQ-006 s_meta_valid/ready/data  in/out/in  1/1/32  upstream tx request: sid=[15:0], len=[31:16] in bytes.
REQ-007 m_meta_valid/ready/data  out/in/out  1/1/32  tx request to the TCP stack, same format.
REQ-008 s_stat_valid/ready/data  in/out/in  1/1/64  stack tx status: sid=[15:0], len=[31:16], space=[61:32], error=[63:62].
REQ-009 m_stat_valid/ready/data  out/in/out  1/1/64  final status to upstream, same format.
REQ-010 s_data_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  DATA_BITS/DATA_BITS/8/1/1/1  upstream payload.
REQ-011 m_data_tdata/tkeep/tlast/tvalid/tready/tid  out/out/out/out/in/out  DATA_BITS/DATA_BITS/8/1/1/1/6  payload to the stack; tid is driven to 0.

Function
REQ-012 SHALL implement FSM states IDLE, META, WAIT_STAT, BACKOFF, DATA, DRAIN and REPORT.
REQ-013 IDLE: s_meta_ready=1; on handshake, latch sid/len, clear retry counter; if len=0 go to REPORT with error=0, space=0, else go to META.
REQ-014 META: m_meta_valid=1 with the latched sid/len; hold data stable until m_meta_ready; on handshake go to WAIT_STAT.
REQ-015 WAIT_STAT: s_stat_ready=1; the accepted status is latched.
REQ-016 WAIT_STAT, error=0: go to DATA with beat counter = ceil(len*8/DATA_BITS); len=64 yields 1 beat at 512-bit width.
REQ-017 WAIT_STAT, error≠0 and retries<MAX_RETRY: increment retries, go to BACKOFF.
REQ-018 WAIT_STAT, error≠0 and retries=MAX_RETRY: go to DRAIN.
REQ-019 BACKOFF: count exactly RETRY_DELAY cycles with all valids and readies deasserted, then go to META.
REQ-020 DATA: s_data_tready = m_data_tready; m_data_tvalid = s_data_tvalid; tdata/tkeep pass through combinationally.
REQ-021 DATA: m_data_tlast SHALL be generated from the beat counter (1 on the final beat), ignoring s_data_tlast; each handshake decrements the counter; after the final beat go to REPORT.
REQ-022 DRAIN: s_data_tready=1, m_data_tvalid=0; discard the same beat count; then go to REPORT with the latched error.
REQ-023 REPORT: m_stat_valid=1 with the latched status and sid/len overwritten by the request values; on handshake go to IDLE.
REQ-024 Exactly one m_stat is produced per accepted s_meta, in request order; no request overlap.
REQ-025 Outside its serving state, every ready/valid SHALL be 0; s_stat beats arriving outside WAIT_STAT are backpressured, not dropped.
REQ-026 Payload bytes are never forwarded to the stack before a status with error=0 has been received for that request.

Reset
REQ-027 While aresetn=0: state=IDLE, counters=0, all valid/ready outputs 0 except s_meta_ready=0, m_data_tlast=0, m_data_tid=0.
REQ-028 s_meta_ready SHALL rise on the first clock after reset release.
REQ-029 Reset mid-transaction SHALL abandon the request with no m_stat and no further m_data beats.

Verification
REQ-030 sid=5, len=128, stat error=0 -> m_meta 0x00800005; 2 data beats, tlast on beat 2; m_stat sid=5 len=128 error=0.
REQ-031 len=100, upstream tlast wrongly on beat 1 -> 2 beats forwarded, m_data_tlast only on beat 2.
REQ-032 First stat error=1, second error=0 -> m_meta issued twice, ≥RETRY_DELAY idle cycles between issues, data forwarded once.
REQ-033 MAX_RETRY=2, all stats error=2 -> 3 m_meta issues, 0 m_data beats, upstream beats drained, m_stat error=2.
REQ-034 len=0 -> no m_meta and no data; m_stat error=0 within 3 cycles.
REQ-035 Random m_data_tready/m_stat_ready/m_meta_ready stalls plus aresetn pulse in DATA -> no beat loss/duplication before reset, idle outputs after.
